// File: rtl/lcd_bus_receiver.sv
// Panel-side HD44780-style bus receiver: samples E/RS/RW/DB[7:4], follows the
// 8-bit to 4-bit power-on sequence, rebuilds bytes, tracks the cursor and emulates busy time.
module lcd_bus_receiver #(
    parameter int unsigned MIN_E_HIGH   = 12,
    parameter int unsigned BUSY_CYCLES  = 2000,
    parameter int unsigned CLEAR_CYCLES = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iLCD_Enabled,
    input  logic       iLCD_RS,
    input  logic       iLCD_RW,
    input  logic [3:0] iLCD_Data,
    output logic       oValid,
    output logic [7:0] oByte,
    output logic       oIsData,
    output logic       oFourBit,
    output logic [6:0] oAddress,
    output logic       oBusy,
    output logic       oViolation,
    output logic [1:0] oState
);

    localparam logic [1:0] MODE8    = 2'd0;
    localparam logic [1:0] MODE4_HI = 2'd1;
    localparam logic [1:0] MODE4_LO = 2'd2;

    localparam int unsigned CNT_W = $clog2(MIN_E_HIGH + 1);
    localparam logic [CNT_W-1:0] E_MIN = CNT_W'(MIN_E_HIGH);

    logic             e_q, e_p_q;
    logic             rs_q, rs_p_q;
    logic             rw_q, rw_p_q;
    logic [3:0]       data_q, data_p_q;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [1:0]       state_q, state_d;
    logic [3:0]       hi_nib_q, hi_nib_d;
    logic             hi_rs_q, hi_rs_d;
    logic             valid_q, valid_d;
    logic [7:0]       byte_q, byte_d;
    logic             is_data_q, is_data_d;
    logic             four_bit_q, four_bit_d;
    logic [6:0]       addr_q, addr_d;
    logic             inc_q, inc_d;
    logic [31:0]      busy_q, busy_d;
    logic             viol_q, viol_d;
    logic             fall;
    logic [7:0]       full_byte;

    // E is judged on the registered copy; RS/RW/Data come from the stage behind it,
    // which on the falling-edge cycle still holds the last E-high sample.
    assign fall      = e_p_q & ~e_q;
    assign full_byte = {hi_nib_q, data_p_q};

    always_comb begin
        hi_cnt_d   = '0;
        state_d    = state_q;
        hi_nib_d   = hi_nib_q;
        hi_rs_d    = hi_rs_q;
        valid_d    = 1'b0;
        byte_d     = byte_q;
        is_data_d  = is_data_q;
        four_bit_d = four_bit_q;
        addr_d     = addr_q;
        inc_d      = inc_q;
        busy_d     = (busy_q != 32'd0) ? busy_q - 32'd1 : 32'd0;
        viol_d     = viol_q;

        if (e_q) begin
            hi_cnt_d = (hi_cnt_q == E_MIN) ? hi_cnt_q : hi_cnt_q + CNT_W'(1);
        end

        if (fall && !rw_p_q) begin
            if (hi_cnt_q != E_MIN) begin
                viol_d = 1'b1;
            end else if (busy_q != 32'd0) begin
                viol_d = 1'b1;
            end else begin
                case (state_q)
                    MODE8: begin
                        valid_d   = 1'b1;
                        byte_d    = {data_p_q, 4'h0};
                        is_data_d = rs_p_q;
                        if (!rs_p_q && data_p_q == 4'h2) begin
                            state_d    = MODE4_HI;
                            four_bit_d = 1'b1;
                        end
                    end
                    MODE4_HI: begin
                        hi_nib_d = data_p_q;
                        hi_rs_d  = rs_p_q;
                        state_d  = MODE4_LO;
                    end
                    MODE4_LO: begin
                        valid_d   = 1'b1;
                        byte_d    = full_byte;
                        is_data_d = hi_rs_q;
                        state_d   = MODE4_HI;
                        busy_d    = BUSY_CYCLES;
                        if (rs_p_q != hi_rs_q) begin
                            viol_d = 1'b1;
                        end
                        // The RS captured with the high nibble decides command vs data.
                        if (hi_rs_q) begin
                            addr_d = inc_q ? addr_q + 7'd1 : addr_q - 7'd1;
                        end else if (full_byte[7]) begin
                            addr_d = full_byte[6:0];
                        end else if (full_byte[7:5] == 3'b001) begin
                            if (full_byte[4]) begin
                                state_d    = MODE8;
                                four_bit_d = 1'b0;
                            end
                        end else if (full_byte == 8'h01) begin
                            addr_d = 7'd0;
                            inc_d  = 1'b1;
                            busy_d = CLEAR_CYCLES;
                        end else if (full_byte[7:1] == 7'b0000001) begin
                            addr_d = 7'd0;
                            busy_d = CLEAR_CYCLES;
                        end else if (full_byte[7:2] == 6'b000001) begin
                            inc_d = full_byte[1];
                        end
                    end
                    default: state_d = MODE8;
                endcase
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            e_q        <= 1'b0;
            e_p_q      <= 1'b0;
            rs_q       <= 1'b0;
            rs_p_q     <= 1'b0;
            rw_q       <= 1'b0;
            rw_p_q     <= 1'b0;
            data_q     <= 4'h0;
            data_p_q   <= 4'h0;
            hi_cnt_q   <= '0;
            state_q    <= MODE8;
            hi_nib_q   <= 4'h0;
            hi_rs_q    <= 1'b0;
            valid_q    <= 1'b0;
            byte_q     <= 8'h00;
            is_data_q  <= 1'b0;
            four_bit_q <= 1'b0;
            addr_q     <= 7'd0;
            inc_q      <= 1'b1;
            busy_q     <= 32'd0;
            viol_q     <= 1'b0;
        end else begin
            e_q        <= iLCD_Enabled;
            e_p_q      <= e_q;
            rs_q       <= iLCD_RS;
            rs_p_q     <= rs_q;
            rw_q       <= iLCD_RW;
            rw_p_q     <= rw_q;
            data_q     <= iLCD_Data;
            data_p_q   <= data_q;
            hi_cnt_q   <= hi_cnt_d;
            state_q    <= state_d;
            hi_nib_q   <= hi_nib_d;
            hi_rs_q    <= hi_rs_d;
            valid_q    <= valid_d;
            byte_q     <= byte_d;
            is_data_q  <= is_data_d;
            four_bit_q <= four_bit_d;
            addr_q     <= addr_d;
            inc_q      <= inc_d;
            busy_q     <= busy_d;
            viol_q     <= viol_d;
        end
    end

    // oValid is a one-cycle pulse with no ready: the consumer must take oByte/oIsData
    // that cycle or later, as they hold until the next pulse.
    assign oValid     = valid_q;
    assign oByte      = byte_q;
    assign oIsData    = is_data_q;
    assign oFourBit   = four_bit_q;
    assign oAddress   = addr_q;
    assign oBusy      = (busy_q != 32'd0);
    assign oViolation = viol_q;
    assign oState     = state_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver: drives E/RS/RW/DB pulses and checks accepted bytes,
// cursor and busy durations against a transaction-level model of the LCD bus rules.
module tb_lcd_bus_receiver;

    localparam int MIN_E   = 12;
    localparam int BUSY_N  = 200;
    localparam int CLEAR_N = 1200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       e = 1'b0;
    logic       rs = 1'b0;
    logic       rw = 1'b0;
    logic [3:0] data = 4'h0;
    logic       o_valid, o_is_data, o_four_bit, o_busy, o_viol;
    logic [7:0] o_byte;
    logic [6:0] o_addr;
    logic [1:0] o_state;

    lcd_bus_receiver #(
        .MIN_E_HIGH  (MIN_E),
        .BUSY_CYCLES (BUSY_N),
        .CLEAR_CYCLES(CLEAR_N)
    ) dut (
        .Clock       (clk),
        .Reset       (rst_n),
        .iLCD_Enabled(e),
        .iLCD_RS     (rs),
        .iLCD_RW     (rw),
        .iLCD_Data   (data),
        .oValid      (o_valid),
        .oByte       (o_byte),
        .oIsData     (o_is_data),
        .oFourBit    (o_four_bit),
        .oAddress    (o_addr),
        .oBusy       (o_busy),
        .oViolation  (o_viol),
        .oState      (o_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: {four_bit, address, is_data, byte} per accepted transfer, plus busy length.
    logic [16:0] exp_q[$];
    int          exp_busy_q[$];
    int          n_valid_exp  = 0;
    int          n_valid_seen = 0;
    logic [16:0] pop_v;
    int          pop_b;

    // Reference model state.
    bit         m_four, m_have_hi, m_hi_rs, m_inc, m_viol;
    logic [3:0] m_hi;
    int         m_addr;
    int         m_free;

    task automatic model_reset();
        m_four = 0; m_have_hi = 0; m_hi_rs = 0; m_inc = 1; m_viol = 0;
        m_hi = 4'h0; m_addr = 0; m_free = 0;
    endtask

    task automatic model_emit(input logic r, input logic [7:0] b, input int busy);
        exp_q.push_back({m_four, 7'(m_addr), r, b});
        exp_busy_q.push_back(busy);
        n_valid_exp++;
    endtask

    // k is the clock edge at which E is first sampled low.
    task automatic model_nibble(input logic r, input logic w, input logic [3:0] nib,
                                input int hi_len, input int k);
        logic [7:0] b;
        int n;
        if (w) return;
        if (hi_len < MIN_E) begin m_viol = 1; return; end
        if (k < m_free) begin m_viol = 1; return; end
        if (!m_four) begin
            if (!r && nib == 4'h2) m_four = 1;
            model_emit(r, {nib, 4'h0}, 0);
            return;
        end
        if (!m_have_hi) begin
            m_hi = nib; m_hi_rs = r; m_have_hi = 1;
            return;
        end
        m_have_hi = 0;
        b = {m_hi, nib};
        n = BUSY_N;
        if (r != m_hi_rs) m_viol = 1;
        if (m_hi_rs) m_addr = (m_addr + (m_inc ? 1 : 127)) % 128;
        else if (b >= 8'h80) m_addr = int'(b) - 128;
        else if (b >= 8'h20 && b < 8'h40) begin
            if (b[4]) m_four = 0;
        end
        else if (b == 8'h01) begin m_addr = 0; m_inc = 1; n = CLEAR_N; end
        else if (b == 8'h02 || b == 8'h03) begin m_addr = 0; n = CLEAR_N; end
        else if (b >= 8'h04 && b < 8'h08) m_inc = b[1];
        model_emit(m_hi_rs, b, n);
        m_free = k + 1 + n;
    endtask

    // Monitor: compares every oValid and measures the busy run that starts with it.
    bit meas = 0;
    int run = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            meas = 0;
        end else begin
            if (o_valid) begin
                n_valid_seen++;
                if (exp_q.size() > 0) begin
                    pop_v = exp_q.pop_front();
                    check("byte", 32'({o_four_bit, o_addr, o_is_data, o_byte}), 32'(pop_v));
                end
                meas = 1;
                run = 0;
            end
            if (meas) begin
                if (o_busy) run++;
                else begin
                    meas = 0;
                    if (exp_busy_q.size() > 0) begin
                        pop_b = exp_busy_q.pop_front();
                        check("busy_len", run, pop_b);
                    end
                end
            end
        end
    end

    // RS/RW/Data are scrambled on the very cycle E falls to prove the last E-high sample is used.
    task automatic send_nibble(input logic r, input logic w, input logic [3:0] nib, input int hi_len);
        @(negedge clk);
        rs = r; rw = w; data = nib; e = 1'b1;
        repeat (hi_len) @(negedge clk);
        e = 1'b0;
        model_nibble(r, w, nib, hi_len, cyc + 1);
        rs = ~r; rw = 1'b1; data = ~nib;
        @(negedge clk);
        rw = 1'b0;
    endtask

    task automatic send_byte(input logic r, input logic [7:0] b, input int l1, input int l2);
        send_nibble(r, 1'b0, b[7:4], l1);
        repeat (3) @(negedge clk);
        send_nibble(r, 1'b0, b[3:0], l2);
    endtask

    task automatic settle();
        int n = 0;
        repeat (4) @(negedge clk);
        while (o_busy && n < CLEAR_N + 100) begin
            @(negedge clk);
            n++;
        end
        if (o_busy) check("busy_timeout", 32'(o_busy), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic checkpoint(input string tag);
        check($sformatf("%s_valid_count", tag), n_valid_seen, n_valid_exp);
        check($sformatf("%s_violation", tag), 32'(o_viol), 32'(m_viol));
        check($sformatf("%s_pending", tag), exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(o_valid), 0);
        check("rst_byte", 32'(o_byte), 0);
        check("rst_is_data", 32'(o_is_data), 0);
        check("rst_four_bit", 32'(o_four_bit), 0);
        check("rst_addr", 32'(o_addr), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_viol", 32'(o_viol), 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic init_seq();
        logic [3:0] seq [4];
        seq = '{4'h3, 4'h3, 4'h3, 4'h2};
        foreach (seq[i]) begin
            send_nibble(1'b0, 1'b0, seq[i], 13);
            repeat (30) @(negedge clk);
        end
        check("init_four_bit", 32'(o_four_bit), 1);
    endtask

    initial begin
        logic [7:0] cmds [4];
        logic       r;
        logic [7:0] b;
        int         base;
        cmds = '{8'h28, 8'h06, 8'h0C, 8'h01};

        pulse_reset();
        init_seq();
        checkpoint("init");

        foreach (cmds[i]) begin
            send_byte(1'b0, cmds[i], 13, 13);
            settle();
        end
        checkpoint("cmds");
        check("addr_after_clear", 32'(o_addr), 0);

        send_byte(1'b1, 8'h41, 12, 12);
        settle();
        check("byte_A", 32'(o_byte), 32'h41);
        check("isdata_A", 32'(o_is_data), 1);
        check("addr_A", 32'(o_addr), 1);
        checkpoint("data_A");

        send_nibble(1'b1, 1'b0, 4'h4, 11);
        repeat (5) @(negedge clk);
        check("short_viol", 32'(o_viol), 1);
        checkpoint("short");
        send_nibble(1'b1, 1'b0, 4'h1, 12);
        repeat (3) @(negedge clk);
        send_nibble(1'b1, 1'b0, 4'h0, 12);
        settle();
        checkpoint("resync");

        pulse_reset();
        init_seq();
        send_byte(1'b0, 8'hFF, 13, 13); settle();
        check("addr_7f", 32'(o_addr), 32'h7F);
        send_byte(1'b1, 8'h20, 13, 13); settle();
        check("addr_wrap_up", 32'(o_addr), 0);
        send_byte(1'b0, 8'h04, 13, 13); settle();
        send_byte(1'b1, 8'h55, 13, 13); settle();
        check("addr_wrap_down", 32'(o_addr), 32'h7F);
        checkpoint("addr");

        send_nibble(1'b0, 1'b1, 4'h8, 14);
        repeat (5) @(negedge clk);
        checkpoint("rw");

        send_byte(1'b1, 8'h41, 13, 13);
        repeat (100) @(negedge clk);
        send_byte(1'b1, 8'h42, 13, 13);
        settle();
        check("busy_viol", 32'(o_viol), 1);
        send_byte(1'b1, 8'h43, 13, 13);
        settle();
        check("after_busy_byte", 32'(o_byte), 32'h43);
        checkpoint("busy");

        for (int i = 0; i < 40; i++) begin
            r = 1'($urandom_range(0, 1));
            b = 8'($urandom_range(0, 255));
            send_byte(r, b, $urandom_range(12, 16), $urandom_range(12, 16));
            settle();
        end
        checkpoint("random");

        pulse_reset();
        init_seq();
        send_nibble(1'b1, 1'b0, 4'hA, 13);
        repeat (5) @(negedge clk);
        checkpoint("pre_rst");
        pulse_reset();
        send_nibble(1'b0, 1'b0, 4'h2, 13);
        settle();
        check("post_rst_byte", 32'(o_byte), 32'h20);
        checkpoint("post_rst");

        base = n_valid_seen;
        @(negedge clk);
        rs = 1'b0; data = 4'h3; e = 1'b1;
        repeat (60) @(negedge clk);
        check("e_stuck_high", n_valid_seen, base);
        e = 1'b0;
        model_nibble(1'b0, 1'b0, 4'h3, 60, cyc + 1);
        settle();
        checkpoint("e_long");

        check("exp_left", exp_q.size(), 0);
        check("busy_exp_left", exp_busy_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
